// File: rtl/manchester_tx_ctrl_if.sv
// rtl/manchester_tx_ctrl_if.sv - upstream byte handshake for the Manchester transmit controller
interface manchester_tx_ctrl_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/manchester_tx_ctrl.sv
// rtl/manchester_tx_ctrl.sv - Manchester transmit sequencer: preamble, LSB-first bytes, half-bit strobes
// Optional even-parity bit per byte when MANCH_TX_PARITY_EN is defined.
module manchester_tx_ctrl #(
  parameter int DIV     = 4,
  parameter int PRE_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  manchester_tx_ctrl_if.slave  s,
  output logic                 enc_rst,
  output logic                 enc_dv,
  output logic                 enc_x,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    PRE,
`ifdef MANCH_TX_PARITY_EN
    DATA,
    PAR
`else
    DATA
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       half_q, half_d;
  logic [4:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       buf_valid_q, buf_valid_d;
  logic [7:0] buf_data_q, buf_data_d;
`ifdef MANCH_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  logic enc_rst_q, enc_rst_d;
  logic enc_dv_q, enc_dv_d;
  logic enc_x_q, enc_x_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic accept, strobe, bit_end, end_byte, load;

  function automatic logic is_active(input state_t st);
    return (st != IDLE) && (st != START);
  endfunction

  assign s.s_ready = ~buf_valid_q;
  assign accept    = s.s_valid & ~buf_valid_q;
  assign strobe    = is_active(state_q) && (cnt_q == 8'(DIV - 1));
  assign bit_end   = strobe & half_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
`ifdef MANCH_TX_PARITY_EN
    par_d        = par_q;
`endif
    frame_done_d = 1'b0;
    end_byte     = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_valid_q) begin
          state_d = START;
          cnt_d   = 8'd0;
        end
      end
      START: begin
        state_d = PRE;
        cnt_d   = 8'd0;
        half_d  = 1'b0;
        bit_d   = 5'd0;
      end
      default: begin
        if (strobe) begin
          cnt_d  = 8'd0;
          half_d = ~half_q;
          if (bit_end) begin
            case (state_q)
              PRE: begin
                if (bit_q == 5'(PRE_LEN - 1)) load = 1'b1;
                else bit_d = bit_q + 5'd1;
              end
              DATA: begin
                if (bit_q == 5'd7) begin
`ifdef MANCH_TX_PARITY_EN
                  state_d = PAR;
`else
                  end_byte = 1'b1;
`endif
                end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 5'd1;
                end
              end
              default: end_byte = 1'b1;
            endcase
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    // Back-to-back bytes chain straight into DATA with no preamble.
    if (end_byte) begin
      if (buf_valid_q) begin
        load = 1'b1;
      end else begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end
    end

    if (load) begin
      state_d = DATA;
      shift_d = buf_data_q;
      bit_d   = 5'd0;
`ifdef MANCH_TX_PARITY_EN
      par_d   = ^buf_data_q;
`endif
    end

    if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = s.s_data;
    end else if (load) begin
      buf_valid_d = 1'b0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    enc_rst_d = (state_d == START);
    busy_d    = (state_d != IDLE);
    enc_dv_d  = is_active(state_d) && (cnt_d == 8'(DIV - 1));
    case (state_d)
      PRE:     enc_x_d = ~bit_d[0];
      DATA:    enc_x_d = shift_d[0];
`ifdef MANCH_TX_PARITY_EN
      PAR:     enc_x_d = par_d;
`endif
      default: enc_x_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      half_q       <= 1'b0;
      bit_q        <= 5'd0;
      shift_q      <= 8'd0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= 8'd0;
`ifdef MANCH_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
      enc_rst_q    <= 1'b0;
      enc_dv_q     <= 1'b0;
      enc_x_q      <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
`ifdef MANCH_TX_PARITY_EN
      par_q        <= par_d;
`endif
      enc_rst_q    <= enc_rst_d;
      enc_dv_q     <= enc_dv_d;
      enc_x_q      <= enc_x_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign enc_rst    = enc_rst_q;
  assign enc_dv     = enc_dv_q;
  assign enc_x      = enc_x_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_manchester_tx_ctrl.sv
// tb/tb_manchester_tx_ctrl.sv - randomized bench for manchester_tx_ctrl against a bit-list reference model
module tb_manchester_tx_ctrl;
  localparam int D0 = 4;
  localparam int P0 = 8;
  localparam int D1 = 1;
  localparam int P1 = 4;
`ifdef MANCH_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  manchester_tx_ctrl_if bus0 ();
  manchester_tx_ctrl_if bus1 ();

  logic enc_rst0, enc_dv0, enc_x0, busy0, frame_done0;
  logic enc_rst1, enc_dv1, enc_x1, busy1, frame_done1;

  manchester_tx_ctrl #(.DIV(D0), .PRE_LEN(P0)) dut (
    .clk(clk), .reset_n(reset_n), .s(bus0.slave),
    .enc_rst(enc_rst0), .enc_dv(enc_dv0), .enc_x(enc_x0),
    .busy(busy0), .frame_done(frame_done0)
  );

  manchester_tx_ctrl #(.DIV(D1), .PRE_LEN(P1)) dut1 (
    .clk(clk), .reset_n(reset_n), .s(bus1.slave),
    .enc_rst(enc_rst1), .enc_dv(enc_dv1), .enc_x(enc_x1),
    .busy(busy1), .frame_done(frame_done1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic sq0[$];
  int   sc0[$];
  int   rc0, rcyc0, fd0, fdcyc0, nbusy0, nr0;
  logic sq1[$];
  int   rc1, fd1, nbusy1;
  logic exp_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (enc_dv0) begin sq0.push_back(enc_x0); sc0.push_back(cyc); end
    if (enc_rst0) begin rc0++; rcyc0 = cyc; end
    if (frame_done0) begin fd0++; fdcyc0 = cyc; end
    if (busy0) nbusy0++;
    if (!bus0.s_ready) nr0++;
    if (enc_dv1) sq1.push_back(enc_x1);
    if (enc_rst1) rc1++;
    if (frame_done1) fd1++;
    if (busy1) nbusy1++;
  end

  task automatic clear_mon();
    sq0.delete(); sc0.delete();
    rc0 = 0; rcyc0 = 0; fd0 = 0; fdcyc0 = 0; nbusy0 = 0; nr0 = 0;
    sq1.delete();
    rc1 = 0; fd1 = 0; nbusy1 = 0;
  endtask

  // Reference: a frame is a preamble of alternating bits then each byte LSB first
  // (plus even parity when enabled); every bit is seen on two consecutive strobes.
  function automatic void build_exp(input int pre, input logic [7:0] b[$]);
    logic v;
    exp_q.delete();
    for (int i = 0; i < pre; i++) begin
      v = (i % 2 == 0);
      exp_q.push_back(v); exp_q.push_back(v);
    end
    foreach (b[j]) begin
      for (int k = 0; k < 8; k++) begin
        v = b[j][k];
        exp_q.push_back(v); exp_q.push_back(v);
      end
      if (PB == 1) begin
        v = ^b[j];
        exp_q.push_back(v); exp_q.push_back(v);
      end
    end
  endfunction

  task automatic drive_bytes(input int sel, input logic [7:0] b[$]);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
      if (sel == 0) begin
        bus0.s_valid = 1'b1;
        if (bus0.s_ready) begin bus0.s_data = b[i]; i++; end
        else bus0.s_data = 8'($urandom);
      end else begin
        bus1.s_valid = 1'b1;
        if (bus1.s_ready) begin bus1.s_data = b[i]; i++; end
        else bus1.s_data = 8'($urandom);
      end
    end
    @(negedge clk); #1;
    bus0.s_valid = 1'b0;
    bus1.s_valid = 1'b0;
  endtask

  task automatic wait_fd(input int sel, input int budget);
    int k = 0;
    while (((sel == 0) ? fd0 : fd1) == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (bus0.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got %b want 1", bus0.s_ready); end
    n_tests++; if (enc_rst0 !== 1'b0) begin n_fail++; $display("FAIL rst_enc_rst got %b want 0", enc_rst0); end
    n_tests++; if (enc_dv0 !== 1'b0) begin n_fail++; $display("FAIL rst_enc_dv got %b want 0", enc_dv0); end
    n_tests++; if (enc_x0 !== 1'b1) begin n_fail++; $display("FAIL rst_enc_x got %b want 1", enc_x0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy0); end
    n_tests++; if (frame_done0 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", frame_done0); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_single_a5();
    logic [7:0] b[$];
    int bad = 0;
    int first_sc, last_sc;
    b.push_back(8'hA5);
    clear_mon();
    build_exp(P0, b);
    drive_bytes(0, b);
    wait_fd(0, 2000);
    if (sq0.size() == exp_q.size()) foreach (exp_q[i]) if (sq0[i] !== exp_q[i]) bad++;
    first_sc = (sc0.size() > 0) ? sc0[0] : -1;
    last_sc  = (sc0.size() > 0) ? sc0[sc0.size()-1] : -1;
    n_tests++; if (sq0.size() != exp_q.size()) begin n_fail++; $display("FAIL a5_strobe_count got %0d want %0d", sq0.size(), exp_q.size()); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL a5_bit_sequence got %0d wrong strobes want 0", bad); end
    n_tests++; if (rc0 != 1) begin n_fail++; $display("FAIL a5_enc_rst_pulses got %0d want 1", rc0); end
    n_tests++; if (first_sc - rcyc0 != D0) begin n_fail++; $display("FAIL a5_first_strobe_delay got %0d want %0d", first_sc - rcyc0, D0); end
    n_tests++; if (fdcyc0 - last_sc != 1) begin n_fail++; $display("FAIL a5_frame_done_delay got %0d want 1", fdcyc0 - last_sc); end
    n_tests++; if (nbusy0 != 1 + D0 * exp_q.size()) begin n_fail++; $display("FAIL a5_busy_cycles got %0d want %0d", nbusy0, 1 + D0 * exp_q.size()); end
    n_tests++; if (fd0 != 1) begin n_fail++; $display("FAIL a5_frame_done_pulses got %0d want 1", fd0); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] b[$];
      int bad = 0;
      int n = (r == 0) ? 2 : int'($urandom_range(5, 3));
      if (r == 0) begin b.push_back(8'h00); b.push_back(8'hFF); end
      else for (int j = 0; j < n; j++) b.push_back(8'($urandom));
      clear_mon();
      build_exp(P0, b);
      drive_bytes(0, b);
      wait_fd(0, 4000);
      if (sq0.size() == exp_q.size()) foreach (exp_q[i]) if (sq0[i] !== exp_q[i]) bad++;
      n_tests++; if (sq0.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_strobe_count got %0d want %0d", r, sq0.size(), exp_q.size()); end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b%0d_bit_sequence got %0d wrong strobes want 0", r, bad); end
      n_tests++; if (rc0 != 1) begin n_fail++; $display("FAIL b2b%0d_enc_rst_pulses got %0d want 1", r, rc0); end
      n_tests++; if (fd0 != 1) begin n_fail++; $display("FAIL b2b%0d_frame_done_pulses got %0d want 1", r, fd0); end
      n_tests++; if (nbusy0 != 1 + D0 * exp_q.size()) begin n_fail++; $display("FAIL b2b%0d_busy_cycles got %0d want %0d", r, nbusy0, 1 + D0 * exp_q.size()); end
      n_tests++; if (nr0 == 0) begin n_fail++; $display("FAIL b2b%0d_ready_low_cycles got %0d want >0", r, nr0); end
    end
  endtask

  task automatic test_div1();
    logic [7:0] b[$];
    int bad = 0;
    int n = int'($urandom_range(3, 1));
    for (int j = 0; j < n; j++) b.push_back(8'($urandom));
    clear_mon();
    build_exp(P1, b);
    drive_bytes(1, b);
    wait_fd(1, 2000);
    if (sq1.size() == exp_q.size()) foreach (exp_q[i]) if (sq1[i] !== exp_q[i]) bad++;
    n_tests++; if (sq1.size() != exp_q.size()) begin n_fail++; $display("FAIL div1_strobe_count got %0d want %0d", sq1.size(), exp_q.size()); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL div1_bit_sequence got %0d wrong strobes want 0", bad); end
    n_tests++; if (nbusy1 != 1 + exp_q.size()) begin n_fail++; $display("FAIL div1_busy_cycles got %0d want %0d", nbusy1, 1 + exp_q.size()); end
    n_tests++; if (rc1 != 1 || fd1 != 1) begin n_fail++; $display("FAIL div1_rst_done_pulses got %0d/%0d want 1/1", rc1, fd1); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [7:0] c[$];
    int k = 0;
    int bad = 0;
    b.push_back(8'($urandom)); b.push_back(8'($urandom));
    clear_mon();
    drive_bytes(0, b);
    while (sq0.size() < 2 * P0 + 7 && k < 2000) begin @(negedge clk); #1; k++; end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy got %b want 0", busy0); end
    n_tests++; if (enc_x0 !== 1'b1 || enc_dv0 !== 1'b0) begin n_fail++; $display("FAIL mid_async_enc got x=%b dv=%b want x=1 dv=0", enc_x0, enc_dv0); end
    n_tests++; if (bus0.s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_s_ready got %b want 1", bus0.s_ready); end
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    clear_mon();
    repeat (30) @(negedge clk);
    #1;
    n_tests++; if (nbusy0 != 0 || rc0 != 0) begin n_fail++; $display("FAIL mid_discard got busy=%0d rst=%0d want 0/0", nbusy0, rc0); end
    n_tests++; if (fd0 != 0) begin n_fail++; $display("FAIL mid_no_frame_done got %0d want 0", fd0); end
    c.push_back(8'($urandom));
    clear_mon();
    build_exp(P0, c);
    drive_bytes(0, c);
    wait_fd(0, 2000);
    if (sq0.size() == exp_q.size()) foreach (exp_q[i]) if (sq0[i] !== exp_q[i]) bad++;
    n_tests++; if (sq0.size() != exp_q.size() || bad != 0) begin n_fail++; $display("FAIL mid_refresh_frame got %0d strobes %0d wrong want %0d strobes 0 wrong", sq0.size(), bad, exp_q.size()); end
    n_tests++; if (rc0 != 1) begin n_fail++; $display("FAIL mid_fresh_enc_rst got %0d want 1", rc0); end
  endtask

  task automatic test_parity();
    logic [7:0] b[$];
    int bad = 0;
    logic p0, p1;
    b.push_back(8'h07); b.push_back(8'h03);
    clear_mon();
    build_exp(P0, b);
    drive_bytes(0, b);
    wait_fd(0, 4000);
    if (sq0.size() == exp_q.size()) foreach (exp_q[i]) if (sq0[i] !== exp_q[i]) bad++;
    n_tests++; if (sq0.size() != exp_q.size() || bad != 0) begin n_fail++; $display("FAIL par_sequence got %0d strobes %0d wrong want %0d strobes 0 wrong", sq0.size(), bad, exp_q.size()); end
`ifdef MANCH_TX_PARITY_EN
    p0 = (sq0.size() > 2 * P0 + 17) ? sq0[2 * P0 + 17] : 1'bx;
    p1 = (sq0.size() > 2 * P0 + 35) ? sq0[2 * P0 + 35] : 1'bx;
    n_tests++; if (p0 !== 1'b1) begin n_fail++; $display("FAIL par_bit_07 got %b want 1", p0); end
    n_tests++; if (p1 !== 1'b0) begin n_fail++; $display("FAIL par_bit_03 got %b want 0", p1); end
    n_tests++; if (sq0.size() != 2 * (P0 + 18)) begin n_fail++; $display("FAIL par_frame_len got %0d want %0d", sq0.size(), 2 * (P0 + 18)); end
`else
    p0 = 1'b0;
    p1 = 1'b0;
    n_tests++; if (sq0.size() != 2 * (P0 + 16) + (p0 ^ p1)) begin n_fail++; $display("FAIL nopar_frame_len got %0d want %0d", sq0.size(), 2 * (P0 + 16)); end
`endif
  endtask

  initial begin
    reset_n      = 1'b0;
    bus0.s_valid = 1'b0;
    bus0.s_data  = 8'h00;
    bus1.s_valid = 1'b0;
    bus1.s_data  = 8'h00;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_div1();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
